// File: rtl/shift_issue_stage.sv
// Decode/issue stage feeding the barrel shifter: decodes R-type shift ops and
// queues them in a small FIFO whose head drives the shifter controls.
module shift_issue_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic [4:0]  sh,
  output logic [31:0] rt,
  output logic [31:0] rs,
  output logic        RegImm,
  output logic        leftRight,
  output logic        AL,
  output logic [4:0]  out_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        illegal,
  output logic [15:0] issued
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        reg_imm;
    logic        left_right;
    logic        al;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_illegal;
  logic [15:0]     r_issued;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_wr;
  logic            w_legal;
  logic            w_reg_imm;
  logic            w_left_right;
  logic            w_al;
  entry_t          w_head;

  // Funct decode into shifter control; anything unlisted is illegal.
  always_comb begin
    w_legal      = 1'b0;
    w_reg_imm    = 1'b0;
    w_left_right = 1'b0;
    w_al         = 1'b0;
    case (in_funct)
      6'b000000: begin w_legal = 1'b1; w_left_right = 1'b1; end
      6'b000010: begin w_legal = 1'b1; end
      6'b000011: begin w_legal = 1'b1; w_al = 1'b1; end
      6'b000100: begin w_legal = 1'b1; w_reg_imm = 1'b1; w_left_right = 1'b1; end
      6'b000110: begin w_legal = 1'b1; w_reg_imm = 1'b1; end
      6'b000111: begin w_legal = 1'b1; w_reg_imm = 1'b1; w_al = 1'b1; end
      default:   ;
    endcase
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));
  assign w_push  = in_valid & ~w_full;
  assign w_wr    = w_push & w_legal;
  assign w_pop   = ~w_empty & out_ready;

  // Pointers, occupancy, illegal pulse and pop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_issued  <= '0;
    end else begin
      r_illegal <= w_push & ~w_legal;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_issued <= r_issued + 16'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is written only by a legal push, so it never needs reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= '{shamt: in_shamt, rs: in_rs, rt: in_rt, rd: in_rd,
                           reg_imm: w_reg_imm, left_right: w_left_right, al: w_al};
    end
  end

  // Head outputs are forced to zero when empty so the shifter sees no stale control.
  assign w_head    = r_mem[r_rd_ptr];
  assign sh        = w_empty ? 5'd0  : w_head.shamt;
  assign rt        = w_empty ? 32'd0 : w_head.rt;
  assign rs        = w_empty ? 32'd0 : w_head.rs;
  assign RegImm    = w_empty ? 1'b0  : w_head.reg_imm;
  assign leftRight = w_empty ? 1'b0  : w_head.left_right;
  assign AL        = w_empty ? 1'b0  : w_head.al;
  assign out_rd    = w_empty ? 5'd0  : w_head.rd;
  assign out_valid = ~w_empty;
  assign in_ready  = ~w_full;
  assign illegal   = r_illegal;
  assign issued    = r_issued;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed testbench for shift_issue_stage (DEPTH=2).
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  sh;
  logic [31:0] rt;
  logic [31:0] rs;
  logic        RegImm;
  logic        leftRight;
  logic        AL;
  logic [4:0]  out_rd;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic [15:0] issued;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_issued = 16'd0;

  shift_issue_stage #(.DEPTH(2), .AW(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .sh(sh), .rt(rt), .rs(rs), .RegImm(RegImm), .leftRight(leftRight), .AL(AL),
    .out_rd(out_rd), .out_valid(out_valid), .out_ready(out_ready),
    .illegal(illegal), .issued(issued)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] vrs,
                       input logic [31:0] vrt, input logic [4:0] vrd);
    in_valid = 1'b1;
    in_funct = f;
    in_shamt = sa;
    in_rs    = vrs;
    in_rt    = vrt;
    in_rd    = vrd;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    step(); step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (issued !== 16'd0) $display("FAIL reset_issued got %0d want 0", issued); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %0b want 0", illegal); else n_pass++;
    n_total++; if ({sh, rt, rs, RegImm, leftRight, AL} !== '0)
      $display("FAIL reset_head_zero got sh=%0d rt=%h rs=%h want all 0", sh, rt, rs); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_sll();
    drive(6'b000000, 5'd5, 32'd0, 32'd7, 5'd3);
    step();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL sll_valid got %0b want 1", out_valid); else n_pass++;
    n_total++; if ({sh, RegImm, leftRight, AL} !== {5'd5, 1'b0, 1'b1, 1'b0})
      $display("FAIL sll_ctrl got sh=%0d ri=%0b lr=%0b al=%0b want 5 0 1 0", sh, RegImm, leftRight, AL); else n_pass++;
    n_total++; if ({rt, out_rd} !== {32'd7, 5'd3})
      $display("FAIL sll_data got rt=%0d rd=%0d want 7 3", rt, out_rd); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_issued++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL sll_pop got %0b want 0", out_valid); else n_pass++;
    n_total++; if (issued !== exp_issued) $display("FAIL sll_issued got %0d want %0d", issued, exp_issued); else n_pass++;
  endtask

  task automatic test_srav();
    out_ready = 1'b1;
    drive(6'b000111, 5'd0, 32'hFFFFFE0C, 32'h80000000, 5'd9);
    step();
    in_valid = 1'b0;
    n_total++; if ({out_valid, RegImm, leftRight, AL} !== 4'b1101)
      $display("FAIL srav_ctrl got v=%0b ri=%0b lr=%0b al=%0b want 1 1 0 1", out_valid, RegImm, leftRight, AL); else n_pass++;
    n_total++; if ({rs, rt} !== {32'hFFFFFE0C, 32'h80000000})
      $display("FAIL srav_data got rs=%h rt=%h want fffffe0c 80000000", rs, rt); else n_pass++;
    step();
    out_ready = 1'b0;
    exp_issued++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL srav_pop got %0b want 0", out_valid); else n_pass++;
    n_total++; if (issued !== exp_issued) $display("FAIL srav_issued got %0d want %0d", issued, exp_issued); else n_pass++;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive(6'b000000, 5'd1, 32'd0, 32'd11, 5'd1);
    step();
    drive(6'b000010, 5'd2, 32'd0, 32'd22, 5'd2);
    step();
    n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0b want 0", in_ready); else n_pass++;
    drive(6'b000011, 5'd3, 32'd0, 32'd33, 5'd4);
    step(); step();
    n_total++; if ({in_ready, out_valid, out_rd} !== {1'b0, 1'b1, 5'd1})
      $display("FAIL full_hold got rdy=%0b v=%0b rd=%0d want 0 1 1", in_ready, out_valid, out_rd); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL full_no_comb_path got %0b want 0", in_ready); else n_pass++;
    step();
    n_total++; if ({out_rd, sh, in_ready} !== {5'd2, 5'd2, 1'b1})
      $display("FAIL drain1 got rd=%0d sh=%0d rdy=%0b want 2 2 1", out_rd, sh, in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++; if ({out_rd, AL, rt} !== {5'd4, 1'b1, 32'd33})
      $display("FAIL drain2 got rd=%0d al=%0b rt=%0d want 4 1 33", out_rd, AL, rt); else n_pass++;
    step();
    out_ready = 1'b0;
    exp_issued += 16'd3;
    n_total++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL drain_empty got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else n_pass++;
    n_total++; if (issued !== exp_issued) $display("FAIL full_issued got %0d want %0d", issued, exp_issued); else n_pass++;
  endtask

  task automatic test_illegal();
    drive(6'b100000, 5'd1, 32'd1, 32'd1, 5'd5);
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL illegal_ready got %0b want 1", in_ready); else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++; if ({illegal, out_valid} !== 2'b10)
      $display("FAIL illegal_pulse got ill=%0b v=%0b want 1 0", illegal, out_valid); else n_pass++;
    step();
    n_total++; if ({illegal, out_valid} !== 2'b00)
      $display("FAIL illegal_clear got ill=%0b v=%0b want 0 0", illegal, out_valid); else n_pass++;
    n_total++; if (issued !== exp_issued) $display("FAIL illegal_issued got %0d want %0d", issued, exp_issued); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int q[$];
    int k = 0;
    bit m_push, m_pop;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 12) drive((k % 2) ? 6'b000110 : 6'b000000, 5'(k), 32'd0, 32'(k * 3 + 1), 5'(k + 10));
      else in_valid = 1'b0;
      out_ready = (cyc >= 2);
      #1;
      if (q.size() > 0) begin
        n_total++;
        if ({out_valid, out_rd, rt, sh} !== {1'b1, 5'(q[0] + 10), 32'(q[0] * 3 + 1), 5'(q[0])})
          $display("FAIL b2b_head cyc=%0d got v=%0b rd=%0d rt=%0d want rd=%0d rt=%0d", cyc, out_valid, out_rd, rt,
                   q[0] + 10, q[0] * 3 + 1);
        else n_pass++;
      end else begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty cyc=%0d got %0b want 0", cyc, out_valid); else n_pass++;
      end
      n_total++;
      if (in_ready !== (q.size() != 2)) $display("FAIL b2b_ready cyc=%0d got %0b want %0b", cyc, in_ready, q.size() != 2);
      else n_pass++;
      m_push = in_valid && (q.size() < 2);
      m_pop  = out_ready && (q.size() > 0);
      step();
      if (m_pop) begin void'(q.pop_front()); exp_issued++; end
      if (m_push) begin q.push_back(k); k++; end
    end
    out_ready = 1'b0;
    n_total++; if (issued !== exp_issued) $display("FAIL b2b_issued got %0d want %0d", issued, exp_issued); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    drive(6'b000000, 5'd1, 32'd0, 32'd1, 5'd1);
    step();
    drive(6'b000100, 5'd2, 32'd2, 32'd2, 5'd2);
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_issued = 16'd0;
    n_total++; if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL rst_async got v=%0b rdy=%0b want 0 1", out_valid, in_ready); else n_pass++;
    n_total++; if ({issued, sh, out_rd} !== {16'd0, 5'd0, 5'd0})
      $display("FAIL rst_async_zero got issued=%0d sh=%0d rd=%0d want 0", issued, sh, out_rd); else n_pass++;
    step();
    reset = 1'b0;
    drive(6'b000010, 5'd6, 32'd0, 32'd99, 5'd7);
    step();
    in_valid = 1'b0;
    n_total++; if ({out_valid, out_rd, sh, issued} !== {1'b1, 5'd7, 5'd6, 16'd0})
      $display("FAIL rst_release got v=%0b rd=%0d sh=%0d issued=%0d want 1 7 6 0", out_valid, out_rd, sh, issued);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sll();
    test_srav();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
